// File: rtl/wvb_reader_pkg.sv
// Shared types and header field layout for the waveform buffer reader.
package wvb_reader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HPOP  = 3'd1,
    HLAT  = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4
  } wvb_state_t;

  localparam int DEF_ADR_WIDTH = 12;
  localparam int HDR_START_LSB = 0;

  function automatic int hdr_stop_lsb(input int adr_width);
    return HDR_START_LSB + adr_width;
  endfunction

  localparam int HDR_STOP_LSB = hdr_stop_lsb(DEF_ADR_WIDTH);

endpackage

// File: rtl/wvb_rd_skid_fifo.sv
// Small synchronous FIFO absorbing RAM read data while the downstream stalls.
module wvb_rd_skid_fifo #(
  parameter int P_WIDTH = 23,
  parameter int P_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [P_WIDTH-1:0]       din,
  output logic [P_WIDTH-1:0]       dout,
  output logic                     empty,
  output logic [$clog2(P_DEPTH):0] occ
);

  localparam int AW = $clog2(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW:0]        wp;
  logic [AW:0]        rp;
  logic               full;

  assign occ   = wp - rp;
  assign empty = (wp == rp);
  assign full  = (occ == (AW+1)'(P_DEPTH));
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wvb_reader.sv
// Per-channel readout sequencer: pops an event header, walks the sample RAM
// from start to stop (wrapping) and streams the samples out over valid/ready.
module wvb_reader
  import wvb_reader_pkg::*;
#(
  parameter int P_DATA_WIDTH  = 22,
  parameter int P_ADR_WIDTH   = DEF_ADR_WIDTH,
  parameter int P_HDR_WIDTH   = 80,
  parameter int P_RAM_LATENCY = 1,
  parameter int P_SKID_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data_in,
  output logic [P_HDR_WIDTH-1:0]  evt_hdr,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic                    busy,
  output logic                    eoe_err,
  output logic [15:0]             evt_cnt
);

  localparam int STOP_LSB = hdr_stop_lsb(P_ADR_WIDTH);
  localparam int OCC_W    = $clog2(P_SKID_DEPTH) + 1;

  wvb_state_t             state;
  logic [P_ADR_WIDTH-1:0] cur_addr;
  logic [P_ADR_WIDTH-1:0] stop_addr;
  logic                   cur_is_stop;
  logic                   issue;
  int unsigned            load;

  // Stage 0 lines up with the wvb_rd_addr register, stage P_RAM_LATENCY with
  // the cycle in which wvb_data_in holds that address's sample.
  logic [P_RAM_LATENCY:0] pipe_v;
  logic [P_RAM_LATENCY:0] pipe_last;
  logic                   exit_v;
  logic                   exit_last;

  logic                    accept;
  logic                    skid_push;
  logic                    skid_pop;
  logic                    skid_empty;
  logic [P_DATA_WIDTH:0]   skid_dout;
  logic [OCC_W-1:0]        skid_occ;

  assign stop_addr   = evt_hdr[STOP_LSB +: P_ADR_WIDTH];
  assign cur_is_stop = (cur_addr == stop_addr);
  assign exit_v      = pipe_v[P_RAM_LATENCY];
  assign exit_last   = pipe_last[P_RAM_LATENCY];

  // Credit counts everything already committed to land in the skid FIFO,
  // less the word leaving this cycle, so the FIFO can never overflow.
  always_comb begin
    load = 32'(skid_occ);
    for (int unsigned i = 0; i <= P_RAM_LATENCY; i++) load += 32'(pipe_v[i]);
    if (accept) load -= 1;
    issue = (state == READ) && (load < P_SKID_DEPTH);
  end

  // The exiting RAM word bypasses the FIFO when it is empty and the sink is
  // ready; otherwise it is queued, so dout stays put across a stall.
  always_comb begin
    dout_valid = !skid_empty || exit_v;
    if (!skid_empty) begin
      {dout, dout_last} = skid_dout;
    end else if (exit_v) begin
      {dout, dout_last} = {wvb_data_in, exit_last};
    end else begin
      dout      = '0;
      dout_last = 1'b0;
    end
  end

  assign accept    = dout_valid && dout_ready;
  assign skid_pop  = !skid_empty && dout_ready;
  assign skid_push = exit_v && !(skid_empty && dout_ready);
  assign busy      = (state != IDLE) || !skid_empty;

  wvb_rd_skid_fifo #(
    .P_WIDTH (P_DATA_WIDTH + 1),
    .P_DEPTH (P_SKID_DEPTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .pop   (skid_pop),
    .din   ({wvb_data_in, exit_last}),
    .dout  (skid_dout),
    .empty (skid_empty),
    .occ   (skid_occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hdr_rdreq   <= 1'b0;
      evt_hdr     <= '0;
      cur_addr    <= '0;
      wvb_rd_addr <= '0;
      pipe_v      <= '0;
      pipe_last   <= '0;
      eoe_err     <= 1'b0;
      evt_cnt     <= '0;
    end else begin
      hdr_rdreq <= 1'b0;
      pipe_v    <= {pipe_v[P_RAM_LATENCY-1:0], issue};
      pipe_last <= {pipe_last[P_RAM_LATENCY-1:0], issue && cur_is_stop};

      if (issue) begin
        wvb_rd_addr <= cur_addr;
        cur_addr    <= cur_addr + 1'b1;
      end

      if (exit_v && (wvb_data_in[0] != exit_last)) eoe_err <= 1'b1;

      case (state)
        IDLE: begin
          if (en && !hdr_empty) begin
            hdr_rdreq <= 1'b1;
            state     <= HPOP;
          end
        end
        HPOP: state <= HLAT;
        HLAT: begin
          evt_hdr  <= hdr_data;
          cur_addr <= hdr_data[HDR_START_LSB +: P_ADR_WIDTH];
          state    <= READ;
        end
        READ: begin
          if (issue && cur_is_stop) state <= DRAIN;
        end
        DRAIN: begin
          if (accept && dout_last) begin
            evt_cnt <= evt_cnt + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench: two readers (RAM latency 1 and 2) share headers and stimulus.
module tb_wvb_reader;

  logic          clk;
  logic          rst;
  logic          en;
  logic          dout_ready;
  logic [79:0]   hdr_mem [16];
  int            hdr_wp;
  logic [4095:0] eoe_mem;
  int            cyc;
  int            n_checks;
  int            n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic        hdr_empty;
    logic        hdr_rdreq;
    logic [79:0] hdr_data;
    logic [11:0] wvb_rd_addr;
    logic [21:0] wvb_data_in;
    logic [79:0] evt_hdr;
    logic [21:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        busy;
    logic        eoe_err;
    logic [15:0] evt_cnt;
    logic [21:0] r1;
    logic [21:0] r2;
    int          rp;
    int          rx_cnt;
    int          rq_cnt;
    int          stall_err;
    int          ovf_err;
    int          fv_cyc = -1;
    int          rx_cyc [1024];
    logic [22:0] rx_word [1024];
    int          rq_cyc [16];
    logic        prev_stall;
    logic [22:0] prev_word;

    wvb_reader #(
      .P_DATA_WIDTH  (22),
      .P_ADR_WIDTH   (12),
      .P_HDR_WIDTH   (80),
      .P_RAM_LATENCY (g + 1),
      .P_SKID_DEPTH  (4)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .hdr_empty   (hdr_empty),
      .hdr_rdreq   (hdr_rdreq),
      .hdr_data    (hdr_data),
      .wvb_rd_addr (wvb_rd_addr),
      .wvb_data_in (wvb_data_in),
      .evt_hdr     (evt_hdr),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .dout_last   (dout_last),
      .busy        (busy),
      .eoe_err     (eoe_err),
      .evt_cnt     (evt_cnt)
    );

    // Non-FWFT header FIFO: data appears the cycle after the pop.
    assign hdr_empty = (rp == hdr_wp);
    always @(posedge clk) begin
      if (hdr_rdreq) begin
        hdr_data <= hdr_mem[rp % 16];
        rp       <= rp + 1;
      end
    end

    // Sample RAM: word = {addr, eoe}, registered once or twice.
    always @(posedge clk) begin
      r1 <= {9'd0, wvb_rd_addr, eoe_mem[wvb_rd_addr]};
      r2 <= r1;
    end
    assign wvb_data_in = (g == 0) ? r1 : r2;

    always @(negedge clk) begin
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (dout_valid !== 1'b1 || {dout, dout_last} !== prev_word))
          stall_err++;
        if (dut.skid_push && !dut.skid_pop && dut.skid_occ == 3'd4) ovf_err++;
        if (hdr_rdreq) begin
          rq_cyc[rq_cnt % 16] = cyc;
          rq_cnt++;
        end
        if (dout_valid && fv_cyc < 0) fv_cyc = cyc;
        if (dout_valid && dout_ready) begin
          rx_word[rx_cnt % 1024] = {dout, dout_last};
          rx_cyc[rx_cnt % 1024]  = cyc;
          rx_cnt++;
        end
        prev_stall = dout_valid && !dout_ready;
        prev_word  = {dout, dout_last};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [11:0] start, input logic [11:0] stop);
    hdr_mem[hdr_wp % 16] = {56'd0, stop, start};
    hdr_wp++;
  endtask

  function automatic logic [22:0] exp_word(input logic [11:0] a, input logic eoe, input logic last);
    return {9'd0, a, eoe, last};
  endfunction

  function automatic logic [22:0] get_word(input int l, input int i);
    return (l == 0) ? g_lane[0].rx_word[i % 1024] : g_lane[1].rx_word[i % 1024];
  endfunction

  function automatic int get_cyc(input int l, input int i);
    return (l == 0) ? g_lane[0].rx_cyc[i % 1024] : g_lane[1].rx_cyc[i % 1024];
  endfunction

  task automatic wait_rx(input string tag, input int tgt);
    int n = 0;
    while ((g_lane[0].rx_cnt < tgt || g_lane[1].rx_cnt < tgt) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 64'(n < 2000), 64'd1);
  endtask

  task automatic check_span(input string tag, input int base, input logic [11:0] start,
                            input int n, input logic eoe_last);
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < n; i++) begin
        logic [11:0] a;
        a = start + 12'(i);
        check($sformatf("%s_l%0d_%0d", tag, l, i), 64'(get_word(l, base + i)),
              64'(exp_word(a, (i == n - 1) ? eoe_last : 1'b0, i == n - 1)));
      end
    end
  endtask

  task automatic lane_status(input string tag, input int cnt, input logic eoe);
    check({tag, "_cnt_l0"}, 64'(g_lane[0].evt_cnt), 64'(cnt));
    check({tag, "_cnt_l1"}, 64'(g_lane[1].evt_cnt), 64'(cnt));
    check({tag, "_eoe_l0"}, 64'(g_lane[0].eoe_err), 64'(eoe));
    check({tag, "_eoe_l1"}, 64'(g_lane[1].eoe_err), 64'(eoe));
    check({tag, "_busy_l0"}, 64'(g_lane[0].busy), 64'd0);
    check({tag, "_busy_l1"}, 64'(g_lane[1].busy), 64'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_outs_l0"}, {9'd0, g_lane[0].dout_valid, g_lane[0].dout, g_lane[0].dout_last,
          g_lane[0].hdr_rdreq, g_lane[0].busy, g_lane[0].evt_cnt, g_lane[0].eoe_err,
          g_lane[0].wvb_rd_addr}, 64'd0);
    check({tag, "_outs_l1"}, {9'd0, g_lane[1].dout_valid, g_lane[1].dout, g_lane[1].dout_last,
          g_lane[1].hdr_rdreq, g_lane[1].busy, g_lane[1].evt_cnt, g_lane[1].eoe_err,
          g_lane[1].wvb_rd_addr}, 64'd0);
    check({tag, "_hdr_l0"}, g_lane[0].evt_hdr[63:0], 64'd0);
    check({tag, "_hdr_l1"}, g_lane[1].evt_hdr[63:0], 64'd0);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    en         = 1'b0;
    dout_ready = 1'b1;
    hdr_wp     = 0;
    eoe_mem    = '0;
    tick(3);
    check_quiet("reset");
    rst = 1'b0;
    tick(2);

    // Basic 4-sample event
    eoe_mem[12'h013] = 1'b1;
    push_hdr(12'h010, 12'h013);
    en = 1'b1;
    wait_rx("t1_wait", 4);
    tick(3);
    check_span("t1", 0, 12'h010, 4, 1'b1);
    check("t1_back2back_l0", 64'(get_cyc(0, 3) - get_cyc(0, 0)), 64'd3);
    check("t1_back2back_l1", 64'(get_cyc(1, 3) - get_cyc(1, 0)), 64'd3);
    check("t1_latency_l0", 64'(g_lane[0].fv_cyc - g_lane[0].rq_cyc[0]), 64'd4);
    check("t1_latency_l1", 64'(g_lane[1].fv_cyc - g_lane[1].rq_cyc[0]), 64'd5);
    check("t1_evt_hdr", g_lane[0].evt_hdr[63:0], 64'h013010);
    lane_status("t1", 1, 1'b0);

    // Wrapped event
    eoe_mem[12'h001] = 1'b1;
    push_hdr(12'hFFE, 12'h001);
    wait_rx("t2_wait", 8);
    tick(3);
    check_span("t2", 4, 12'hFFE, 4, 1'b1);
    check("t2_evt_hdr", g_lane[1].evt_hdr[63:0], 64'h001FFE);
    lane_status("t2", 2, 1'b0);

    // 64 samples under random backpressure
    eoe_mem[12'h23F] = 1'b1;
    push_hdr(12'h200, 12'h23F);
    n = 0;
    while ((g_lane[0].rx_cnt < 72 || g_lane[1].rx_cnt < 72) && n < 2000) begin
      @(posedge clk);
      #1;
      dout_ready = 1'($urandom_range(0, 1));
      n++;
    end
    dout_ready = 1'b1;
    check("t3_wait", 64'(n < 2000), 64'd1);
    tick(3);
    check_span("t3", 8, 12'h200, 64, 1'b1);
    check("t3_stall_l0", 64'(g_lane[0].stall_err), 64'd0);
    check("t3_stall_l1", 64'(g_lane[1].stall_err), 64'd0);
    check("t3_ovf_l0", 64'(g_lane[0].ovf_err), 64'd0);
    check("t3_ovf_l1", 64'(g_lane[1].ovf_err), 64'd0);
    lane_status("t3", 3, 1'b0);

    // Single-sample event followed by a queued header
    eoe_mem[12'h100] = 1'b1;
    eoe_mem[12'h301] = 1'b1;
    push_hdr(12'h100, 12'h100);
    push_hdr(12'h300, 12'h301);
    wait_rx("t4_wait", 75);
    tick(3);
    check_span("t4a", 72, 12'h100, 1, 1'b1);
    check_span("t4b", 73, 12'h300, 2, 1'b1);
    n = g_lane[0].rq_cyc[4] - get_cyc(0, 72);
    check("t4_restart_l0", 64'(n >= 1 && n <= 3), 64'd1);
    n = g_lane[1].rq_cyc[4] - get_cyc(1, 72);
    check("t4_restart_l1", 64'(n >= 1 && n <= 3), 64'd1);
    lane_status("t4", 5, 1'b0);

    // Missing eoe flag at the stop address
    push_hdr(12'h400, 12'h402);
    wait_rx("t5_wait", 78);
    tick(3);
    check_span("t5", 75, 12'h400, 3, 1'b0);
    lane_status("t5", 6, 1'b1);
    tick(5);
    lane_status("t5_sticky", 6, 1'b1);

    // Reset in the middle of a stalled READ
    dout_ready = 1'b0;
    eoe_mem[12'h53F] = 1'b1;
    push_hdr(12'h500, 12'h53F);
    tick(10);
    check("t6_busy_l0", 64'(g_lane[0].busy), 64'd1);
    check("t6_busy_l1", 64'(g_lane[1].busy), 64'd1);
    check("t6_credit_l0", 64'(g_lane[0].wvb_rd_addr), 64'h503);
    check("t6_credit_l1", 64'(g_lane[1].wvb_rd_addr), 64'h503);
    check("t6_hold_l0", 64'({g_lane[0].dout_valid, g_lane[0].dout, g_lane[0].dout_last}),
          64'({1'b1, exp_word(12'h500, 1'b0, 1'b0)}));
    check("t6_hold_l1", 64'({g_lane[1].dout_valid, g_lane[1].dout, g_lane[1].dout_last}),
          64'({1'b1, exp_word(12'h500, 1'b0, 1'b0)}));
    #3;
    rst = 1'b1;
    #1;
    check_quiet("t6_async_rst");
    tick(2);
    rst        = 1'b0;
    dout_ready = 1'b1;
    eoe_mem[12'h603] = 1'b1;
    push_hdr(12'h600, 12'h603);
    wait_rx("t6_wait", 82);
    tick(3);
    check_span("t6", 78, 12'h600, 4, 1'b1);
    lane_status("t6", 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
